// File: rtl/uart_msg_tx_sequencer.sv
// -----------------------------------------------------------------------------
// uart_msg_tx_sequencer
//
// Streams a fixed-length message onto a byte-wide UART transmitter, one byte
// per transmit handshake, most significant byte first.  Optionally appends a
// CR LF trailer after the payload.  A single-cycle done pulse marks the end of
// the final byte's transmission.
//
// Handshake per byte:
//   SEND      wait for the transmitter to be idle, then issue one strobe
//   WAIT_ACK  wait for the transmitter to raise busy; if it never does within
//             ACK_TIMEOUT cycles the byte is assumed accepted
//   WAIT_DONE wait for busy to fall, then advance to the next byte or finish
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous, active-high reset
//   i_msg_data  message to send, byte 0 in the top 8 bits
//   i_msg_stb   send request, honoured only while o_msg_busy is low
//   o_msg_busy  high from the cycle after acceptance until the done cycle
//   o_msg_done  one-cycle pulse when the last byte has been transmitted
//   o_tx_data   byte for the transmitter, stable from strobe to next strobe
//   o_tx_stb    one-cycle transmit strobe
//   i_tx_busy   transmitter busy
// -----------------------------------------------------------------------------
module uart_msg_tx_sequencer #(
  parameter int unsigned NBYTES         = 10,
  parameter int unsigned APPEND_NEWLINE = 1,
  parameter int unsigned ACK_TIMEOUT    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*NBYTES-1:0] i_msg_data,
  input  logic                i_msg_stb,
  output logic                o_msg_busy,
  output logic                o_msg_done,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_stb,
  input  logic                i_tx_busy
);

  // Total bytes on the wire per message, payload plus optional CR LF.
  localparam int unsigned TOTAL = NBYTES + 2 * APPEND_NEWLINE;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned TW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned SW    = 8 * TOTAL;

  localparam logic [CW-1:0] CNT_LAST   = CW'(TOTAL - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  // Trailer occupies the low 16 bits of the shift register, so it naturally
  // follows the payload as bytes are shifted out of the top.
  localparam logic [SW-1:0] NEWLINE_TAIL =
    (APPEND_NEWLINE != 0) ? SW'(16'h0D0A) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  state_e          state_q,   state_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [TW-1:0]   timer_q,   timer_d;
  logic [SW-1:0]   shift_q,   shift_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;
  logic            stb_q,     stb_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic            byte_done;
  logic [SW-1:0]   load_val;

  // Message as it will appear on the wire: payload in the top bytes, trailer
  // (if enabled) below it.
  assign load_val = (SW'(i_msg_data) << (16 * APPEND_NEWLINE)) | NEWLINE_TAIL;

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d starts from its held value so no branch can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    stb_d     = 1'b0;
    tx_data_d = tx_data_q;
    byte_done = 1'b0;

    case (state_q)
      IDLE: begin
        // The done cycle is spent here, so a request on that cycle is taken
        // without a dead cycle between messages.
        if (i_msg_stb) begin
          shift_d = load_val;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        // Never strobe into a busy transmitter; only one byte in flight.
        if (!i_tx_busy) begin
          stb_d     = 1'b1;
          tx_data_d = shift_q[SW-1 -: 8];
          timer_d   = '0;
          state_d   = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        // A transmitter that never reports busy (e.g. very fast, or one that
        // swallowed the strobe) must not stall the message forever.
        if (i_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TIMER_LAST) begin
          byte_done = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!i_tx_busy) begin
          byte_done = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Shared exit for a completed byte, from either WAIT_ACK or WAIT_DONE.
    if (byte_done) begin
      if (cnt_q != CNT_LAST) begin
        cnt_d   = cnt_q + 1'b1;
        shift_d = shift_q << 8;
        state_d = SEND;
      end else begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset aborts a message immediately; a frame already handed to the
      // transmitter is left to finish on its own.
      state_q   <= IDLE;
      cnt_q     <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stb_q     <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      stb_q     <= stb_d;
      tx_data_q <= tx_data_d;
    end
  end

  // NOTE: the message shift register is pure datapath and is always reloaded
  // on acceptance before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign o_msg_busy = busy_q;
  assign o_msg_done = done_q;
  assign o_tx_stb   = stb_q;
  assign o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_msg_tx_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// Bench for uart_msg_tx_sequencer.  A message-level reference model (a queue of
// bytes still to send plus timestamps of the current strobe) predicts the
// outputs every cycle; directed scenarios add literal expectations and a
// randomized phase varies data, transmitter timing and ignored requests.
// -----------------------------------------------------------------------------
module tb_uart_msg_tx_sequencer;

  localparam int NBYTES         = 10;
  localparam int APPEND_NEWLINE = 1;
  localparam int ACK_TIMEOUT    = 4;
  localparam int TOTAL          = NBYTES + 2 * APPEND_NEWLINE;

  localparam logic [79:0] MSG1   = 80'h41424344454647484950;
  localparam logic [79:0] MSG30  = 80'h30313233343536373839;
  localparam logic [79:0] MSG_X  = 80'hA5A5_5A5A_DEAD_BEEF_0102;

  localparam logic [7:0] EXP1 [12] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                                      8'h47, 8'h48, 8'h49, 8'h50, 8'h0D, 8'h0A};
  localparam logic [7:0] EXP30 [12] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                       8'h36, 8'h37, 8'h38, 8'h39, 8'h0D, 8'h0A};

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [8*NBYTES-1:0] i_msg_data = '0;
  logic                i_msg_stb = 1'b0;
  logic                o_msg_busy;
  logic                o_msg_done;
  logic [7:0]          o_tx_data;
  logic                o_tx_stb;
  logic                i_tx_busy = 1'b0;

  always #5 clk = ~clk;

  uart_msg_tx_sequencer #(
    .NBYTES         (NBYTES),
    .APPEND_NEWLINE (APPEND_NEWLINE),
    .ACK_TIMEOUT    (ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_msg_data (i_msg_data),
    .i_msg_stb  (i_msg_stb),
    .o_msg_busy (o_msg_busy),
    .o_msg_done (o_msg_done),
    .o_tx_data  (o_tx_data),
    .o_tx_stb   (o_tx_stb),
    .i_tx_busy  (i_tx_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transmitter model: after each strobe, busy rises u_rise cycles later and
  // stays high for u_len cycles.  uart_never keeps busy low; uart_force holds
  // it high regardless of strobes.
  // ---------------------------------------------------------------------------
  bit uart_force = 1'b0;
  bit uart_never = 1'b0;
  int u_rise     = 1;
  int u_len_cfg  = 3;
  int u_delay    = 0;
  int u_left     = 0;
  int u_len      = 0;

  initial forever begin
    @(negedge clk);
    if (uart_force) begin
      i_tx_busy = 1'b1;
      u_delay   = 0;
      u_left    = 0;
    end else begin
      if (u_delay > 0) begin
        u_delay--;
        if (u_delay == 0) u_left = u_len;
      end
      if (u_left > 0) begin
        i_tx_busy = 1'b1;
        u_left--;
      end else begin
        i_tx_busy = 1'b0;
      end
      if (o_tx_stb === 1'b1 && !uart_never) begin
        u_delay = u_rise;
        u_len   = u_len_cfg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model.  Works on the inputs sampled at each rising edge and
  // predicts the outputs for the cycle that edge begins.
  // ---------------------------------------------------------------------------
  logic [7:0] m_q [$];
  bit         m_active   = 1'b0;
  bit         m_eligible = 1'b0;
  bit         m_inflight = 1'b0;
  bit         m_acked    = 1'b0;
  bit         m_fin      = 1'b0;
  int         m_stb_cyc  = 0;
  int         m_age      = 0;
  logic       e_stb      = 1'b0;
  logic       e_done     = 1'b0;
  logic       e_busy     = 1'b0;
  logic [7:0] e_data     = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc++;
    e_stb  = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      m_q.delete();
      m_active   = 1'b0;
      m_eligible = 1'b0;
      m_inflight = 1'b0;
      m_acked    = 1'b0;
      e_data     = 8'h00;
    end else if (!m_active) begin
      if (i_msg_stb) begin
        m_q.delete();
        for (int k = 0; k < NBYTES; k++) m_q.push_back(i_msg_data[8*(NBYTES-k)-1 -: 8]);
        if (APPEND_NEWLINE != 0) begin
          m_q.push_back(8'h0D);
          m_q.push_back(8'h0A);
        end
        m_active   = 1'b1;
        m_eligible = 1'b1;
      end
    end else if (m_eligible) begin
      if (!i_tx_busy) begin
        e_stb      = 1'b1;
        e_data     = m_q[0];
        m_eligible = 1'b0;
        m_inflight = 1'b1;
        m_acked    = 1'b0;
        m_stb_cyc  = cyc;
      end
    end else if (m_inflight) begin
      // Age 0 is the strobe cycle itself; the byte is given up on after
      // ACK_TIMEOUT cycles without busy.
      m_age = (cyc - 1) - m_stb_cyc;
      m_fin = 1'b0;
      if (!m_acked) begin
        if (i_tx_busy) m_acked = 1'b1;
        else if (m_age >= ACK_TIMEOUT - 1) m_fin = 1'b1;
      end else if (!i_tx_busy) begin
        m_fin = 1'b1;
      end
      if (m_fin) begin
        m_q.delete(0);
        m_inflight = 1'b0;
        if (m_q.size() == 0) begin
          m_active = 1'b0;
          e_done   = 1'b1;
        end else begin
          m_eligible = 1'b1;
        end
      end
    end
    e_busy = m_active;
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and capture of the transmitted stream.
  // ---------------------------------------------------------------------------
  logic [7:0] got [$];
  int         stb_at [$];
  int         done_cnt = 0;

  initial forever begin
    @(posedge clk);
    #1;
    check("tx_stb",   64'(o_tx_stb),   64'(e_stb));
    check("msg_done", 64'(o_msg_done), 64'(e_done));
    check("msg_busy", 64'(o_msg_busy), 64'(e_busy));
    check("tx_data",  64'(o_tx_data),  64'(e_data));
    if (o_tx_stb === 1'b1) begin
      got.push_back(o_tx_data);
      stb_at.push_back(cyc);
    end
    if (o_msg_done === 1'b1) done_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input logic [79:0] d);
    @(negedge clk);
    i_msg_data = d;
    i_msg_stb  = 1'b1;
    @(negedge clk);
    i_msg_stb  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (o_msg_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"},   64'(o_msg_done), 64'(1));
    check({name, "_busy_on_done"}, 64'(o_msg_busy), 64'(0));
  endtask

  task automatic wait_strobes(input string name, input int count, input int budget);
    int n = 0;
    while (got.size() < count && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_strobes_reached"}, 64'(got.size() >= count), 64'(1));
  endtask

  task automatic check_stream(input string name, input logic [7:0] exp [12]);
    check({name, "_len"}, 64'(got.size()), 64'(TOTAL));
    for (int i = 0; i < TOTAL; i++) begin
      if (i < got.size()) check($sformatf("%s_byte%0d", name, i), 64'(got[i]), 64'(exp[i]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  int base;
  int drop_cyc;
  int n;
  logic [79:0] rd;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(o_msg_busy), 64'(0));
    check("rst_done", 64'(o_msg_done), 64'(0));
    check("rst_stb",  64'(o_tx_stb),   64'(0));
    check("rst_data", 64'(o_tx_data),  64'(8'h00));
    rst = 1'b0;
    idle(2);

    // Normal transmitter: busy for 3 cycles, starting 1 cycle after strobe.
    got.delete();
    base = done_cnt;
    request(MSG1);
    wait_done("t1", 400);
    check_stream("t1", EXP1);
    check("t1_done_count", 64'(done_cnt - base), 64'(1));
    idle(3);

    // A second request mid-message is ignored.
    got.delete();
    base = done_cnt;
    request(MSG1);
    wait_strobes("t2", 3, 200);
    request(MSG_X);
    wait_done("t2", 400);
    check_stream("t2", EXP1);
    idle(30);
    check("t2_no_extra_bytes", 64'(got.size()), 64'(TOTAL));
    check("t2_done_count", 64'(done_cnt - base), 64'(1));
    check("t2_idle_busy", 64'(o_msg_busy), 64'(0));

    // Transmitter that never raises busy: each byte rides the ack timeout.
    uart_never = 1'b1;
    idle(8);
    got.delete();
    stb_at.delete();
    base = done_cnt;
    request(MSG1);
    wait_done("t3", 400);
    check_stream("t3", EXP1);
    check("t3_done_count", 64'(done_cnt - base), 64'(1));
    for (int i = 1; i < stb_at.size(); i++)
      check($sformatf("t3_gap%0d", i), 64'(stb_at[i] - stb_at[i-1]), 64'(ACK_TIMEOUT + 1));
    uart_never = 1'b0;
    idle(3);

    // Transmitter busy when the request arrives: first strobe follows the fall.
    @(posedge clk);
    #2;
    uart_force = 1'b1;
    got.delete();
    stb_at.delete();
    base = done_cnt;
    request(MSG1);
    idle(19);
    check("t4_no_stb_while_busy", 64'(got.size()), 64'(0));
    @(posedge clk);
    #2;
    uart_force = 1'b0;
    drop_cyc   = cyc;
    wait_strobes("t4", 1, 20);
    if (got.size() > 0) begin
      check("t4_first_byte",  64'(got[0]),    64'(8'h41));
      check("t4_first_cycle", 64'(stb_at[0]), 64'(drop_cyc + 1));
    end
    wait_done("t4", 400);
    check_stream("t4", EXP1);
    idle(3);

    // Reset after the 5th strobe aborts the message; a new one restarts.
    got.delete();
    base = done_cnt;
    request(MSG1);
    wait_strobes("t5", 5, 200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy_after_rst", 64'(o_msg_busy), 64'(0));
    check("t5_stb_after_rst",  64'(o_tx_stb),   64'(0));
    idle(40);
    check("t5_no_more_bytes", 64'(got.size()), 64'(5));
    check("t5_no_done",       64'(done_cnt - base), 64'(0));
    got.delete();
    request(MSG1);
    wait_done("t5b", 400);
    check_stream("t5b", EXP1);
    idle(3);

    // Request held on the done cycle is accepted back to back.
    got.delete();
    base = done_cnt;
    request(MSG1);
    wait_done("t6a", 400);
    got.delete();
    i_msg_data = MSG30;
    i_msg_stb  = 1'b1;
    @(negedge clk);
    i_msg_stb  = 1'b0;
    check("t6_busy_after_chain", 64'(o_msg_busy), 64'(1));
    wait_done("t6b", 400);
    check_stream("t6", EXP30);
    check("t6_done_count", 64'(done_cnt - base), 64'(2));
    idle(3);

    // Randomized messages, transmitter timing and ignored requests.
    for (int m = 0; m < 25; m++) begin
      u_rise     = ($urandom_range(0, 5) == 0) ? 6 : int'($urandom_range(1, 3));
      u_len_cfg  = $urandom_range(1, 6);
      uart_never = ($urandom_range(0, 5) == 0);
      rd         = {16'($urandom), $urandom, $urandom};
      got.delete();
      base = done_cnt;
      @(negedge clk);
      i_msg_data = rd;
      i_msg_stb  = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (o_msg_done === 1'b1) begin
          i_msg_stb = 1'b0;
          break;
        end
        if ($urandom_range(0, 7) == 0) begin
          i_msg_stb  = 1'b1;
          i_msg_data = {16'($urandom), $urandom, $urandom};
        end else begin
          i_msg_stb  = 1'b0;
        end
      end while (n < 3000);
      i_msg_stb = 1'b0;
      check($sformatf("rnd%0d_done_seen", m), 64'(o_msg_done), 64'(1));
      check($sformatf("rnd%0d_len", m), 64'(got.size()), 64'(TOTAL));
      if (got.size() > 0)
        check($sformatf("rnd%0d_first", m), 64'(got[0]), 64'(rd[79:72]));
      idle($urandom_range(0, 3));
    end
    uart_never = 1'b0;

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before the summary (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
